// File: rtl/data_mem_responder_pkg.sv
// Shared definitions for the data memory responder: access size codes and FSM states.
// The misalignment trap is gated by the DMEM_MISALIGN_TRAP_EN macro (see dmem_lane_align).
package data_mem_responder_pkg;

   localparam logic [1:0] SZ_BYTE = 2'b00;
   localparam logic [1:0] SZ_HALF = 2'b01;
   localparam logic [1:0] SZ_WORD = 2'b10;
   localparam logic [1:0] SZ_RSVD = 2'b11;

   typedef enum logic [1:0] {
      ST_IDLE = 2'b00,
      ST_WAIT = 2'b01,
      ST_RESP = 2'b10
   } state_e;

   function automatic logic is_word(input logic [1:0] size);
      return (size == SZ_WORD) || (size == SZ_RSVD);
   endfunction

endpackage

// File: rtl/dmem_lane_align.sv
// Byte-enable generation, store lane shift and load lane select/extension.
// DMEM_MISALIGN_TRAP_EN: when defined, misaligned half/word accesses are flagged; otherwise aligned down silently.
module dmem_lane_align
   import data_mem_responder_pkg::*;
(
   input  logic [1:0]  addr_lo,
   input  logic [1:0]  size,
   input  logic        ld_unsigned,
   input  logic [31:0] wdata,
   input  logic [31:0] rword,
   output logic [3:0]  be,
   output logic [31:0] wlane,
   output logic [31:0] ldata,
   output logic        misalign
);

   logic [1:0]  off;
   logic [31:0] shifted;
   logic        sx;

   always_comb begin
      off = 2'b00;
      be  = 4'b1111;
      if (size == SZ_BYTE) begin
         off = addr_lo;
         be  = 4'b0001 << addr_lo;
      end else if (size == SZ_HALF) begin
         off = {addr_lo[1], 1'b0};
         be  = 4'b0011 << {addr_lo[1], 1'b0};
      end
   end

   assign wlane   = wdata << {off, 3'b000};
   assign shifted = rword >> {off, 3'b000};

   always_comb begin
      sx    = 1'b0;
      ldata = shifted;
      if (size == SZ_BYTE) begin
         sx    = ~ld_unsigned & shifted[7];
         ldata = {{24{sx}}, shifted[7:0]};
      end else if (size == SZ_HALF) begin
         sx    = ~ld_unsigned & shifted[15];
         ldata = {{16{sx}}, shifted[15:0]};
      end
   end

`ifdef DMEM_MISALIGN_TRAP_EN
   assign misalign = ((size == SZ_HALF) && addr_lo[0]) ||
                     (is_word(size) && (addr_lo != 2'b00));
`else
   assign misalign = 1'b0;
`endif

endmodule

// File: rtl/data_mem_responder.sv
// Multi-cycle data memory responder: fixed wait states, byte/half/word access, sign/zero extension.
// Optional misalignment trap via DMEM_MISALIGN_TRAP_EN (handled in dmem_lane_align).
module data_mem_responder
   import data_mem_responder_pkg::*;
#(
   parameter int DEPTH_WORDS = 1024,
   parameter int WAIT_CYCLES = 2
)(
   input  logic        clk,
   input  logic        rst,
   input  logic        req,
   input  logic        we,
   input  logic [31:0] addr,
   input  logic [31:0] wdata,
   input  logic [1:0]  size,
   input  logic        ld_unsigned,
   output logic        busy,
   output logic        ready,
   output logic [31:0] rdata,
   output logic        err
);

   localparam int AW = $clog2(DEPTH_WORDS);
   localparam logic [3:0] CNT_LAST = (WAIT_CYCLES == 0) ? 4'd0 : 4'(WAIT_CYCLES - 1);

   state_e       state_q, state_d;
   logic [3:0]   cnt_q, cnt_d;
   logic         accept, commit;

   logic           we_q;
   logic [AW+1:0]  addr_q;
   logic [31:0]    wdata_q;
   logic [1:0]     size_q;
   logic           uns_q;

   logic [31:0]  mem [DEPTH_WORDS];
   logic [AW-1:0] idx;
   logic [31:0]  rword;
   logic [3:0]   be;
   logic [31:0]  wlane;
   logic [31:0]  ldata;
   logic         misalign;

   assign idx   = addr_q[AW+1:2];
   assign rword = mem[idx];

   dmem_lane_align u_align (
      .addr_lo     (addr_q[1:0]),
      .size        (size_q),
      .ld_unsigned (uns_q),
      .wdata       (wdata_q),
      .rword       (rword),
      .be          (be),
      .wlane       (wlane),
      .ldata       (ldata),
      .misalign    (misalign)
   );

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state_q <= ST_IDLE;
         cnt_q   <= 4'd0;
      end else begin
         state_q <= state_d;
         cnt_q   <= cnt_d;
      end
   end

   always_comb begin
      state_d = state_q;
      cnt_d   = cnt_q;
      accept  = 1'b0;
      commit  = 1'b0;
      case (state_q)
         ST_IDLE: begin
            if (req) begin
               accept  = 1'b1;
               cnt_d   = 4'd0;
               state_d = (WAIT_CYCLES == 0) ? ST_RESP : ST_WAIT;
            end
         end
         ST_WAIT: begin
            if (cnt_q == CNT_LAST) begin
               cnt_d   = 4'd0;
               state_d = ST_RESP;
            end else begin
               cnt_d = cnt_q + 4'd1;
            end
         end
         ST_RESP: begin
            commit  = 1'b1;
            state_d = ST_IDLE;
         end
         default: state_d = ST_IDLE;
      endcase
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         busy    <= 1'b0;
         ready   <= 1'b0;
         rdata   <= 32'd0;
         err     <= 1'b0;
         we_q    <= 1'b0;
         addr_q  <= '0;
         wdata_q <= 32'd0;
         size_q  <= SZ_BYTE;
         uns_q   <= 1'b0;
      end else begin
         ready <= commit;
         if (accept) begin
            busy    <= 1'b1;
            we_q    <= we;
            addr_q  <= addr[AW+1:0];
            wdata_q <= wdata;
            size_q  <= size;
            uns_q   <= ld_unsigned;
         end
         if (commit) begin
            busy <= 1'b0;
            err  <= misalign;
            if (misalign)
               rdata <= 32'd0;
            else if (!we_q)
               rdata <= ldata;
         end
      end
   end

   // RAM is deliberately not reset; only the RESP state can write it, so reset aborts a store.
   always_ff @(posedge clk) begin
      if (commit && we_q && !misalign) begin
         for (int i = 0; i < 4; i++) begin
            if (be[i])
               mem[idx][8*i +: 8] <= wlane[8*i +: 8];
         end
      end
   end

endmodule
